// File: rtl/bsnce_pkg.sv
// bsnce_pkg -- definitions shared by the bit-serial neuron compute engine.
//   seq_state_e : sequencer FSM encoding (IDLE, CLEAR, SHIFT, DRAIN, EMIT)
//   bit_w()     : width of a bit-plane index for a given input word width
//   nrn_w()     : width of a neuron row index for a given row count
// Both helpers clamp to 1 bit so that degenerate sizes (1 plane, 1 row)
// still produce legal port widths.
package bsnce_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_SHIFT = 3'd2,
        ST_DRAIN = 3'd3,
        ST_EMIT  = 3'd4
    } seq_state_e;

    function automatic int bit_w(input int data_w);
        return (data_w > 1) ? $clog2(data_w) : 1;
    endfunction

    function automatic int nrn_w(input int n_out);
        return (n_out > 1) ? $clog2(n_out) : 1;
    endfunction

endpackage

// File: rtl/mac_sequencer.sv
// mac_sequencer -- walks a bit-serial MAC through one input vector.
// For every neuron row: one accumulator-clear cycle, DATA_W bit-plane cycles
// (MSB/sign plane first), PIPE_LAT drain cycles for the MAC pipeline, then a
// result presented with a valid/ready handshake. After N_OUT rows the input
// buffer is released.
//
// Ports
//   clk, rst_n    : clock, asynchronous active-low reset
//   vector_done   : pulse, input buffer holds a complete vector (start)
//   abort         : synchronous abort of the vector in progress
//   out_ready     : downstream accepts the presented result
//   busy          : MAC owns the input buffer (high outside IDLE)
//   mac_clear     : clear the MAC accumulator
//   mac_en        : MAC consumes bit-plane bit_idx this cycle
//   bit_idx       : current bit-plane index
//   bit_msb       : current plane is the sign plane (MAC subtracts)
//   neuron_idx    : current weight row
//   out_valid     : accumulator result for neuron_idx is valid
//   err_overrun   : sticky, vector_done seen while busy
//
// All outputs come straight from flops: the next-state process computes the
// next value of every output from the next state, and one register stage
// holds them.
module mac_sequencer
    import bsnce_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int N_OUT    = 8,
    parameter int PIPE_LAT = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       vector_done,
    input  logic                       abort,
    input  logic                       out_ready,
    output logic                       busy,
    output logic                       mac_clear,
    output logic                       mac_en,
    output logic [bit_w(DATA_W)-1:0]   bit_idx,
    output logic                       bit_msb,
    output logic [nrn_w(N_OUT)-1:0]    neuron_idx,
    output logic                       out_valid,
    output logic                       err_overrun
);

    localparam int BIT_W = bit_w(DATA_W);
    localparam int NRN_W = nrn_w(N_OUT);
    localparam int DRN_W = bit_w(PIPE_LAT);

    localparam logic [BIT_W-1:0] BIT_TOP  = BIT_W'(DATA_W - 1);
    localparam logic [NRN_W-1:0] NRN_LAST = NRN_W'(N_OUT - 1);
    // Drain counter is loaded with PIPE_LAT-1 and leaves DRAIN when it hits 0.
    localparam logic [DRN_W-1:0] DRN_LOAD = (PIPE_LAT > 0) ? DRN_W'(PIPE_LAT - 1) : '0;

    seq_state_e        state_q, state_d;
    logic [DRN_W-1:0]  drn_q, drn_d;
    logic [BIT_W-1:0]  bit_d;
    logic [NRN_W-1:0]  nrn_d;
    logic              busy_d, clear_d, en_d, msb_d, ov_d, err_d;

    always_comb begin
        state_d = state_q;
        drn_d   = drn_q;
        bit_d   = bit_idx;
        nrn_d   = neuron_idx;
        // A second vector cannot be queued; flag it and drop it.
        err_d   = err_overrun | (vector_done && (state_q != ST_IDLE));

        unique case (state_q)
            ST_IDLE: begin
                if (vector_done) begin
                    state_d = ST_CLEAR;
                    nrn_d   = '0;
                end
            end
            ST_CLEAR: begin
                state_d = ST_SHIFT;
                bit_d   = BIT_TOP;
            end
            ST_SHIFT: begin
                if (bit_idx == '0) begin
                    if (PIPE_LAT == 0) begin
                        state_d = ST_EMIT;
                    end else begin
                        state_d = ST_DRAIN;
                        drn_d   = DRN_LOAD;
                    end
                end else begin
                    bit_d = bit_idx - 1'b1;
                end
            end
            ST_DRAIN: begin
                if (drn_q == '0) state_d = ST_EMIT;
                else             drn_d   = drn_q - 1'b1;
            end
            ST_EMIT: begin
                // Result and row index stay frozen until the handshake.
                if (out_ready) begin
                    if (neuron_idx == NRN_LAST) begin
                        state_d = ST_IDLE;
                        nrn_d   = '0;
                    end else begin
                        state_d = ST_CLEAR;
                        nrn_d   = neuron_idx + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort overrides every transition, including a start in IDLE.
        if (abort) begin
            state_d = ST_IDLE;
            drn_d   = '0;
            bit_d   = '0;
            nrn_d   = '0;
        end

        // Output decode from the next state keeps outputs registered and
        // makes clear/en/valid mutually exclusive by construction.
        busy_d  = (state_d != ST_IDLE);
        clear_d = (state_d == ST_CLEAR);
        en_d    = (state_d == ST_SHIFT);
        ov_d    = (state_d == ST_EMIT);
        msb_d   = (state_d == ST_SHIFT) && (bit_d == BIT_TOP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            drn_q       <= '0;
            busy        <= 1'b0;
            mac_clear   <= 1'b0;
            mac_en      <= 1'b0;
            bit_idx     <= '0;
            bit_msb     <= 1'b0;
            neuron_idx  <= '0;
            out_valid   <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            state_q     <= state_d;
            drn_q       <= drn_d;
            busy        <= busy_d;
            mac_clear   <= clear_d;
            mac_en      <= en_d;
            bit_idx     <= bit_d;
            bit_msb     <= msb_d;
            neuron_idx  <= nrn_d;
            out_valid   <= ov_d;
            err_overrun <= err_d;
        end
    end

endmodule

// File: tb/tb_mac_sequencer.sv
// tb_mac_sequencer -- directed stimulus with a scoreboard. The stimulus
// process pushes expected handshakes (row, cycle, valid-hold length) and
// cycle-stamped probes; a negedge monitor pops and compares them, and also
// checks the bit-plane order, stall hold and clear/en/valid exclusivity.
// A second instance covers PIPE_LAT=0, N_OUT=1.
module tb_mac_sequencer;

    localparam int DW = 16;
    localparam int NO = 4;
    localparam int PL = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic vector_done = 1'b0, abort = 1'b0, out_ready = 1'b1;
    logic busy, mac_clear, mac_en, bit_msb, out_valid, err_overrun;
    logic [3:0] bit_idx;
    logic [1:0] neuron_idx;

    logic vd0 = 1'b0, ab0 = 1'b0, rdy0 = 1'b1;
    logic busy0, clr0, en0, msb0, ov0, err0;
    logic [3:0] bit0;
    logic [0:0] nrn0;

    mac_sequencer #(.DATA_W(DW), .N_OUT(NO), .PIPE_LAT(PL)) dut (
        .clk(clk), .rst_n(rst_n), .vector_done(vector_done), .abort(abort),
        .out_ready(out_ready), .busy(busy), .mac_clear(mac_clear), .mac_en(mac_en),
        .bit_idx(bit_idx), .bit_msb(bit_msb), .neuron_idx(neuron_idx),
        .out_valid(out_valid), .err_overrun(err_overrun)
    );

    mac_sequencer #(.DATA_W(DW), .N_OUT(1), .PIPE_LAT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .vector_done(vd0), .abort(ab0),
        .out_ready(rdy0), .busy(busy0), .mac_clear(clr0), .mac_en(en0),
        .bit_idx(bit0), .bit_msb(msb0), .neuron_idx(nrn0),
        .out_valid(ov0), .err_overrun(err0)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int nrn; int cyc; int hold; } emit_t;
    typedef enum int { P_BUSY, P_ERR, P_MACEN, P_OV, P_NRN, P_BIT, P_BUSYRUN,
                       P_ALLZERO, P_EN0, P_OV0, P_BUSY0RUN } probe_e;
    typedef struct { int cyc; probe_e sel; int exp; } probe_t;

    emit_t  emit_q[$];
    probe_t probe_q[$];
    int     total = 0, bad = 0;
    bit     done_req = 1'b0;

    // monitor state
    int en_cnt = 0, msb_cnt = 0, ov_run = 0;
    int busy_run = 0, last_busy_run = 0, busy0_run = 0, last_busy0_run = 0;
    int en0_cnt = 0, last_en0 = -10;
    bit prev_stall = 1'b0;
    int prev_nrn = 0;
    emit_t e;

    function automatic void probe(input int c, input probe_e s, input int x);
        probe_t p;
        p.cyc = c; p.sel = s; p.exp = x;
        probe_q.push_back(p);
    endfunction

    function automatic void expect_emit(input int n, input int c, input int h);
        emit_t t;
        t.nrn = n; t.cyc = c; t.hold = h;
        emit_q.push_back(t);
    endfunction

    function automatic int probe_val(input probe_e s);
        case (s)
            P_BUSY:     return int'(busy);
            P_ERR:      return int'(err_overrun);
            P_MACEN:    return int'(mac_en);
            P_OV:       return int'(out_valid);
            P_NRN:      return int'(neuron_idx);
            P_BIT:      return int'(bit_idx);
            P_BUSYRUN:  return last_busy_run;
            P_ALLZERO:  return int'({busy, mac_clear, mac_en, bit_idx, bit_msb,
                                     neuron_idx, out_valid, err_overrun});
            P_EN0:      return int'(en0);
            P_OV0:      return int'(ov0);
            P_BUSY0RUN: return last_busy0_run;
            default:    return -1;
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        chk("mutex", int'((int'(mac_clear) + int'(mac_en) + int'(out_valid)) > 1), 0);

        if (busy) busy_run++;
        else begin
            if (busy_run != 0) last_busy_run = busy_run;
            busy_run = 0;
        end
        if (busy0) busy0_run++;
        else begin
            if (busy0_run != 0) last_busy0_run = busy0_run;
            busy0_run = 0;
        end

        if (!busy) begin en_cnt = 0; msb_cnt = 0; ov_run = 0; end
        if (mac_en) begin
            chk("bit_idx_order", int'(bit_idx), DW - 1 - en_cnt);
            chk("bit_msb", int'(bit_msb), int'(en_cnt == 0));
            en_cnt++;
            if (bit_msb) msb_cnt++;
        end

        if (prev_stall) begin
            chk("stall_valid_held", int'(out_valid), 1);
            chk("stall_nrn_stable", int'(neuron_idx), prev_nrn);
        end
        prev_stall = out_valid && !out_ready;
        prev_nrn   = int'(neuron_idx);

        if (out_valid) ov_run++;
        if (out_valid && out_ready) begin
            chk("emit_expected", int'(emit_q.size() > 0), 1);
            if (emit_q.size() > 0) begin
                e = emit_q.pop_front();
                chk("emit_cycle", cyc, e.cyc);
                chk("emit_nrn", int'(neuron_idx), e.nrn);
                chk("emit_hold", ov_run, e.hold);
                chk("mac_en_per_nrn", en_cnt, DW);
                chk("msb_per_nrn", msb_cnt, 1);
            end
            en_cnt = 0; msb_cnt = 0; ov_run = 0;
        end else if (emit_q.size() > 0 && emit_q[0].cyc < cyc) begin
            e = emit_q.pop_front();
            chk("emit_missing", cyc, e.cyc);
        end

        if (!busy0) en0_cnt = 0;
        if (en0) begin en0_cnt++; last_en0 = cyc; end
        if (ov0) begin
            chk("ov0_follows_en", cyc, last_en0 + 1);
            chk("en0_count", en0_cnt, DW);
        end

        for (int i = probe_q.size() - 1; i >= 0; i--) begin
            if (probe_q[i].cyc <= cyc) begin
                chk(probe_q[i].sel.name(),
                    (probe_q[i].cyc == cyc) ? probe_val(probe_q[i].sel) : -1,
                    probe_q[i].exp);
                probe_q.delete(i);
            end
        end

        if (done_req) begin
            chk("emit_q_drained", emit_q.size(), 0);
            chk("probe_q_drained", probe_q.size(), 0);
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // b = cycle in which vector_done is driven; CLEAR shows at b+1.
    task automatic start_vec(output int b);
        @(posedge clk); #1;
        vector_done = 1'b1;
        b = cyc;
        @(posedge clk); #1;
        vector_done = 1'b0;
    endtask

    task automatic push_normal(input int b);
        for (int n = 0; n < NO; n++) expect_emit(n, b + 20 + 20 * n, 1);
    endtask

    int b;

    initial begin
        // reset state
        probe(1, P_ALLZERO, 0);
        probe(2, P_ALLZERO, 0);
        wait_until(3);
        rst_n = 1'b1;

        // plain vector, out_ready high
        start_vec(b);
        push_normal(b);
        probe(b + 1, P_BUSY, 1);
        probe(b + 2, P_BIT, 15);
        probe(b + 17, P_BIT, 0);
        probe(b + 18, P_MACEN, 0);
        probe(b + 61, P_NRN, 3);
        probe(b + 82, P_BUSYRUN, 80);
        wait_until(b + 90);

        // back-pressure on neuron 1 for 5 cycles
        start_vec(b);
        expect_emit(0, b + 20, 1);
        expect_emit(1, b + 45, 6);
        expect_emit(2, b + 65, 1);
        expect_emit(3, b + 85, 1);
        probe(b + 42, P_NRN, 1);
        probe(b + 87, P_BUSYRUN, 85);
        wait_until(b + 30);
        out_ready = 1'b0;
        wait_until(b + 45);
        out_ready = 1'b1;
        wait_until(b + 95);

        // abort in the 8th SHIFT cycle of neuron 2, then restart
        start_vec(b);
        expect_emit(0, b + 20, 1);
        expect_emit(1, b + 40, 1);
        probe(b + 49, P_MACEN, 1);
        probe(b + 49, P_BIT, 8);
        probe(b + 50, P_BUSY, 0);
        probe(b + 50, P_MACEN, 0);
        probe(b + 50, P_NRN, 0);
        for (int k = 55; k <= 75; k += 10) begin
            probe(b + k, P_MACEN, 0);
            probe(b + k, P_OV, 0);
        end
        wait_until(b + 49);
        abort = 1'b1;
        wait_until(b + 50);
        abort = 1'b0;
        wait_until(b + 80);
        start_vec(b);
        push_normal(b);
        probe(b + 1, P_NRN, 0);
        probe(b + 1, P_BUSY, 1);
        wait_until(b + 90);

        // abort and vector_done together in IDLE
        abort = 1'b1;
        vector_done = 1'b1;
        b = cyc;
        probe(b + 1, P_BUSY, 0);
        probe(b + 2, P_BUSY, 0);
        probe(b + 2, P_ERR, 0);
        wait_until(b + 1);
        abort = 1'b0;
        vector_done = 1'b0;
        wait_until(b + 5);

        // vector_done during SHIFT: sticky error, sequence unchanged
        start_vec(b);
        push_normal(b);
        probe(b + 9, P_ERR, 0);
        probe(b + 12, P_ERR, 1);
        probe(b + 85, P_ERR, 1);
        probe(b + 82, P_BUSYRUN, 80);
        wait_until(b + 10);
        vector_done = 1'b1;
        wait_until(b + 11);
        vector_done = 1'b0;
        wait_until(b + 90);

        // reset during DRAIN of neuron 0: outputs clear with no clock edge
        start_vec(b);
        wait_until(b + 18);
        rst_n = 1'b0;
        probe(b + 18, P_ALLZERO, 0);
        wait_until(b + 20);
        rst_n = 1'b1;
        probe(b + 21, P_BUSY, 0);
        wait_until(b + 22);
        start_vec(b);
        push_normal(b);
        probe(b + 82, P_BUSYRUN, 80);
        probe(b + 85, P_ERR, 0);
        wait_until(b + 90);

        // PIPE_LAT=0, N_OUT=1 instance
        @(posedge clk); #1;
        vd0 = 1'b1;
        b = cyc;
        @(posedge clk); #1;
        vd0 = 1'b0;
        probe(b + 17, P_EN0, 1);
        probe(b + 17, P_OV0, 0);
        probe(b + 18, P_OV0, 1);
        probe(b + 18, P_EN0, 0);
        probe(b + 20, P_BUSY0RUN, 18);
        wait_until(b + 25);

        done_req = 1'b1;
    end

endmodule

// File: doc/mac_sequencer.md
MAC_SEQUENCER -- requirements
Module: mac_sequencer

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning input word width and number of bit-planes per neuron.
REQ-002 SHALL have parameter N_OUT, default 8, meaning number of neuron rows evaluated per input vector.
REQ-003 SHALL have parameter PIPE_LAT, default 2, meaning MAC datapath latency in cycles (0 allowed).
REQ-004 SHALL use one clock; reset is asynchronous and active-low: clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 vector_done  in  1  one-cycle pulse: input buffer holds a complete vector.
REQ-007 abort  in  1  synchronous abort of the current vector.
REQ-008 out_ready  in  1  downstream accepts a result.
REQ-009 busy  out  1  input buffer stall; MAC owns the vector.
REQ-010 mac_clear  out  1  clear MAC accumulator.
REQ-011 mac_en  out  1  MAC consumes bit-plane bit_idx this cycle.
REQ-012 bit_idx  out  BIT_W=$clog2(DATA_W)  current bit-plane index.
REQ-013 bit_msb  out  1  current plane is the sign plane (subtract).
REQ-014 neuron_idx  out  NRN_W=max(1,$clog2(N_OUT))  current weight row.
REQ-015 out_valid  out  1  accumulator result for neuron_idx is valid.
REQ-016 err_overrun  out  1  sticky: vector_done arrived while busy.

Function
REQ-017 SHALL implement FSM states IDLE, CLEAR, SHIFT, DRAIN, EMIT; all outputs registered.
REQ-018 IDLE: on vector_done -> CLEAR, neuron_idx=0, busy=1 from next cycle.
REQ-019 CLEAR: exactly one cycle, mac_clear=1, then -> SHIFT with bit_idx=DATA_W-1.
REQ-020 SHIFT: exactly DATA_W cycles, mac_en=1, bit_idx decrements DATA_W-1 down to 0 (MSB first), bit_msb=1 only when bit_idx==DATA_W-1; after bit_idx==0 -> DRAIN (or EMIT if PIPE_LAT==0).
REQ-021 DRAIN: exactly PIPE_LAT cycles, mac_en=0, then -> EMIT.
REQ-022 EMIT: out_valid=1, neuron_idx stable, held until out_ready; no drop or change while out_valid && !out_ready.
REQ-023 On EMIT handshake with neuron_idx<N_OUT-1: neuron_idx+1, -> CLEAR next cycle.
REQ-024 On EMIT handshake with neuron_idx==N_OUT-1: -> IDLE, busy=0 next cycle, neuron_idx=0.
REQ-025 Per-neuron latency with out_ready=1: 2+DATA_W+PIPE_LAT cycles (CLEAR+SHIFT+DRAIN+EMIT).
REQ-026 busy SHALL be 1 in every state except IDLE.
REQ-027 vector_done while not IDLE SHALL be ignored and set err_overrun; only reset clears it.
REQ-028 abort has priority over all transitions: -> IDLE next cycle, counters zero, out_valid/mac_en/mac_clear/busy=0; abort in IDLE is a no-op.
REQ-029 abort and vector_done in the same IDLE cycle: abort wins, vector not started, no error.
REQ-030 mac_clear, mac_en, out_valid SHALL be mutually exclusive in every cycle.

Reset
REQ-031 On rst_n low, asynchronously: state=IDLE, busy=0, mac_clear=0, mac_en=0, bit_idx=0, bit_msb=0, neuron_idx=0, out_valid=0, err_overrun=0.
REQ-032 Reset mid-operation SHALL discard the vector in progress; first cycle after release is IDLE.

Structure
REQ-033 Shared package bsnce_pkg SHALL hold the FSM state enum and width helpers (BIT_W, NRN_W functions).
REQ-034 No sub-module required; bit and neuron counters are inline in a single always_ff plus next-state always_comb.

Verification (DATA_W=16, N_OUT=4, PIPE_LAT=2 unless stated)
REQ-035 One vector_done, out_ready=1 -> 4 out_valid pulses, neuron_idx 0..3, 20 cycles apart; busy high 80 cycles; 16 mac_en per neuron, bit_msb only on first.
REQ-036 out_ready=0 for 5 cycles on neuron 1 -> out_valid held 6 cycles, neuron_idx=1 stable, busy high 85 cycles total.
REQ-037 abort at 8th SHIFT cycle of neuron 2 -> next cycle IDLE, busy=0, no further mac_en/out_valid; new vector_done restarts at neuron 0.
REQ-038 vector_done pulsed during SHIFT -> err_overrun=1 and stays 1; sequence completes unchanged.
REQ-039 rst_n asserted during DRAIN -> all outputs zero immediately without clock edge; after release, vector_done runs a clean sequence.
REQ-040 PIPE_LAT=0, N_OUT=1 -> out_valid cycle immediately follows last mac_en; busy high 18 cycles.
